// File: rtl/caliptra_m_axi_sram_responder_if.sv
// AXI4 bundle between the Caliptra M_AXI initiator and the SRAM responder.
// Contents:
//   - AW, W, B, AR and R channels, using the AXI4 signal names.
//   - master modport: the initiator side (Caliptra, or the testbench).
//   - slave modport: the responder side.
// Clock and reset are not in this bundle; they are plain module ports.
interface caliptra_m_axi_sram_responder_if;
    logic [31:0] AWADDR;
    logic [1:0]  AWBURST;
    logic [2:0]  AWSIZE;
    logic [7:0]  AWLEN;
    logic [31:0] AWUSER;
    logic [15:0] AWID;
    logic        AWLOCK;
    logic        AWVALID;
    logic        AWREADY;

    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;

    logic [1:0]  BRESP;
    logic [15:0] BID;
    logic        BVALID;
    logic        BREADY;

    logic [31:0] ARADDR;
    logic [1:0]  ARBURST;
    logic [2:0]  ARSIZE;
    logic [7:0]  ARLEN;
    logic [31:0] ARUSER;
    logic [15:0] ARID;
    logic        ARLOCK;
    logic        ARVALID;
    logic        ARREADY;

    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic [15:0] RID;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWBURST, AWSIZE, AWLEN, AWUSER, AWID, AWLOCK, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BID, BVALID,
        output BREADY,
        output ARADDR, ARBURST, ARSIZE, ARLEN, ARUSER, ARID, ARLOCK, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RID, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWBURST, AWSIZE, AWLEN, AWUSER, AWID, AWLOCK, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BRESP, BID, BVALID,
        input  BREADY,
        input  ARADDR, ARBURST, ARSIZE, ARLEN, ARUSER, ARID, ARLOCK, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RID, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/caliptra_m_axi_sram_responder.sv
// AXI4 subordinate that terminates the Caliptra M_AXI port. The port is backed
// by a local word-addressed SRAM.
//
// Operation:
//   - Only one transaction is in flight at a time.
//   - Read and write grants alternate priority.
//   - A read beat takes 2 cycles: one SRAM cycle plus one R-channel cycle.
//
// Ports:
//   core_clk  : sole clock
//   axi_reset : synchronous, active-high reset (SRAM contents are kept)
//   axi       : AXI4 slave modport of caliptra_m_axi_sram_responder_if
//
// Parameters:
//   DEPTH_WORDS : SRAM depth in 32-bit words (power of two)
//   BASE_ADDR   : byte address mapped to word 0
//
// Optional macro CALIPTRA_M_AXI_RESP_EXCL_EN adds a single-entry exclusive
// monitor. Without it, AWLOCK/ARLOCK are ignored and EXOKAY is never returned.
module caliptra_m_axi_sram_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic core_clk,
    input logic axi_reset,
    caliptra_m_axi_sram_responder_if.slave axi
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_RESP = 3'd2,
        RD_MEM  = 3'd3,
        RD_DATA = 3'd4
    } state_t;

    // Per-beat error check: out of window, too wide, illegal wrap length or
    // reserved burst type.
    function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst, input logic [7:0] len);
        logic e;
        e = 1'b0;
        if (addr < BASE_ADDR) begin
            e = 1'b1;
        end
        if (((addr - BASE_ADDR) >> 2) >= 32'(DEPTH_WORDS)) begin
            e = 1'b1;
        end
        if (size > 3'd2) begin
            e = 1'b1;
        end
        if ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            e = 1'b1;
        end
        if (burst == 2'b11) begin
            e = 1'b1;
        end
        return e;
    endfunction

    // Word index within the SRAM. The low two address bits are dropped, so
    // narrow and unaligned accesses rely on WSTRB alone.
    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // Next beat address. WRAP stays inside a (LEN+1)*4-byte aligned window.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = addr + 32'd4;
            BURST_WRAP:  nxt = (addr & ~mask) | ((addr + 32'd4) & mask);
            default:     nxt = addr + 32'd4;
        endcase
        return nxt;
    endfunction

    logic [31:0]      mem_r [DEPTH_WORDS];

    state_t           state_r;
    logic             prio_w_r;
    logic [15:0]      id_r;
    logic [31:0]      addr_r;
    logic [7:0]       len_r;
    logic [1:0]       burst_r;
    logic [2:0]       size_r;
    logic [7:0]       beat_r;
    logic             werr_r;

    logic             wready_r;
    logic             bvalid_r;
    logic [1:0]       bresp_r;
    logic [15:0]      bid_r;
    logic             rvalid_r;
    logic [1:0]       rresp_r;
    logic [15:0]      rid_r;
    logic [31:0]      rdata_r;
    logic             rlast_r;

    logic             awready_s;
    logic             arready_s;
    logic             w_fire_s;
    logic             cur_err_s;
    logic             last_beat_s;
    logic             wlast_bad_s;
    logic             wr_allow_s;
    logic             mem_we_s;
    logic [IDX_W-1:0] mem_idx_s;
    logic [1:0]       ok_resp_s;
    logic             unused_s;

`ifdef CALIPTRA_M_AXI_RESP_EXCL_EN
    logic             lock_r;
    logic             excl_ok_r;
    logic             resv_valid_r;
    logic [15:0]      resv_id_r;
    logic [29:0]      resv_addr_r;
    logic             aw_match_s;

    assign aw_match_s = resv_valid_r && (resv_id_r == axi.AWID) &&
                        (resv_addr_r == axi.AWADDR[31:2]);
    // An unmatched locked write is accepted but must not reach the SRAM.
    assign wr_allow_s = ~lock_r | excl_ok_r;
    assign ok_resp_s  = (lock_r && (state_r != IDLE) &&
                         (state_r inside {RD_MEM, RD_DATA} || excl_ok_r)) ? RESP_EXOKAY : RESP_OKAY;
`else
    assign wr_allow_s = 1'b1;
    assign ok_resp_s  = RESP_OKAY;
`endif

    // USER and, without the monitor, LOCK signals are accepted and ignored.
    assign unused_s = ^{axi.AWUSER, axi.ARUSER, axi.AWLOCK, axi.ARLOCK};

    assign awready_s = (state_r == IDLE) & axi.AWVALID & (~axi.ARVALID | prio_w_r);
    assign arready_s = (state_r == IDLE) & axi.ARVALID & (~axi.AWVALID | ~prio_w_r);

    assign w_fire_s    = (state_r == WR_DATA) & wready_r & axi.WVALID;
    assign cur_err_s   = beat_err(addr_r, size_r, burst_r, len_r);
    assign last_beat_s = (beat_r == len_r);
    assign wlast_bad_s = (axi.WLAST != last_beat_s);
    assign mem_idx_s   = word_idx(addr_r);
    assign mem_we_s    = w_fire_s & ~cur_err_s & wr_allow_s & ~axi_reset;

    assign axi.AWREADY = awready_s;
    assign axi.ARREADY = arready_s;
    assign axi.WREADY  = wready_r;
    assign axi.BVALID  = bvalid_r;
    assign axi.BRESP   = bresp_r;
    assign axi.BID     = bid_r;
    assign axi.RVALID  = rvalid_r;
    assign axi.RRESP   = rresp_r;
    assign axi.RID     = rid_r;
    assign axi.RDATA   = rdata_r;
    assign axi.RLAST   = rlast_r;

    // SRAM byte-lane writes; contents survive reset.
    always_ff @(posedge core_clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.WSTRB[b]) begin
                    mem_r[mem_idx_s][8*b +: 8] <= axi.WDATA[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM: arbitration, beat sequencing, responses and SRAM reads.
    always_ff @(posedge core_clk) begin
        if (axi_reset) begin
            state_r  <= IDLE;
            prio_w_r <= 1'b1;
            id_r     <= 16'd0;
            addr_r   <= 32'd0;
            len_r    <= 8'd0;
            burst_r  <= 2'd0;
            size_r   <= 3'd0;
            beat_r   <= 8'd0;
            werr_r   <= 1'b0;
            wready_r <= 1'b0;
            bvalid_r <= 1'b0;
            bresp_r  <= 2'd0;
            bid_r    <= 16'd0;
            rvalid_r <= 1'b0;
            rresp_r  <= 2'd0;
            rid_r    <= 16'd0;
            rdata_r  <= 32'd0;
            rlast_r  <= 1'b0;
`ifdef CALIPTRA_M_AXI_RESP_EXCL_EN
            lock_r       <= 1'b0;
            excl_ok_r    <= 1'b0;
            resv_valid_r <= 1'b0;
            resv_id_r    <= 16'd0;
            resv_addr_r  <= 30'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (awready_s) begin
                        id_r     <= axi.AWID;
                        addr_r   <= axi.AWADDR;
                        len_r    <= axi.AWLEN;
                        burst_r  <= axi.AWBURST;
                        size_r   <= axi.AWSIZE;
                        beat_r   <= 8'd0;
                        werr_r   <= 1'b0;
                        wready_r <= 1'b1;
                        prio_w_r <= 1'b0;
                        state_r  <= WR_DATA;
`ifdef CALIPTRA_M_AXI_RESP_EXCL_EN
                        lock_r    <= axi.AWLOCK;
                        excl_ok_r <= axi.AWLOCK & aw_match_s;
                        if (axi.AWLOCK && aw_match_s) begin
                            resv_valid_r <= 1'b0;
                        end
`endif
                    end else if (arready_s) begin
                        id_r     <= axi.ARID;
                        addr_r   <= axi.ARADDR;
                        len_r    <= axi.ARLEN;
                        burst_r  <= axi.ARBURST;
                        size_r   <= axi.ARSIZE;
                        beat_r   <= 8'd0;
                        prio_w_r <= 1'b1;
                        state_r  <= RD_MEM;
`ifdef CALIPTRA_M_AXI_RESP_EXCL_EN
                        lock_r    <= axi.ARLOCK;
                        excl_ok_r <= 1'b0;
                        if (axi.ARLOCK) begin
                            resv_valid_r <= 1'b1;
                            resv_id_r    <= axi.ARID;
                            resv_addr_r  <= axi.ARADDR[31:2];
                        end
`endif
                    end
                end
                WR_DATA: begin
                    if (w_fire_s) begin
                        werr_r <= werr_r | cur_err_s | wlast_bad_s;
`ifdef CALIPTRA_M_AXI_RESP_EXCL_EN
                        if (!lock_r && !cur_err_s && resv_valid_r &&
                            (addr_r[31:2] == resv_addr_r)) begin
                            resv_valid_r <= 1'b0;
                        end
`endif
                        if (last_beat_s) begin
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bid_r    <= id_r;
                            bresp_r  <= (werr_r | cur_err_s | wlast_bad_s) ? RESP_SLVERR : ok_resp_s;
                            state_r  <= WR_RESP;
                        end else begin
                            addr_r <= next_addr(addr_r, burst_r, len_r);
                            beat_r <= beat_r + 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi.BREADY) begin
                        bvalid_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RD_MEM: begin
                    rvalid_r <= 1'b1;
                    rid_r    <= id_r;
                    rlast_r  <= last_beat_s;
                    if (cur_err_s) begin
                        rdata_r <= 32'd0;
                        rresp_r <= RESP_SLVERR;
                    end else begin
                        rdata_r <= mem_r[mem_idx_s];
                        rresp_r <= ok_resp_s;
                    end
                    state_r <= RD_DATA;
                end
                RD_DATA: begin
                    if (axi.RREADY) begin
                        rvalid_r <= 1'b0;
                        if (rlast_r) begin
                            state_r <= IDLE;
                        end else begin
                            addr_r  <= next_addr(addr_r, burst_r, len_r);
                            beat_r  <= beat_r + 8'd1;
                            state_r <= RD_MEM;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_caliptra_m_axi_sram_responder.sv
module tb_caliptra_m_axi_sram_responder;
    logic clk;
    logic rst;

    caliptra_m_axi_sram_responder_if bus();

    caliptra_m_axi_sram_responder #(
        .DEPTH_WORDS(4096),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .core_clk (clk),
        .axi_reset(rst),
        .axi      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [2:0]  wsize;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] raddr;
        logic [2:0]  rsize;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t        vecs [8];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for handshake", nm);
    endtask

    task automatic idle_bus();
        bus.AWADDR = 32'd0; bus.AWBURST = 2'b01; bus.AWSIZE = 3'd2; bus.AWLEN = 8'd0;
        bus.AWUSER = 32'd0; bus.AWID = 16'd0; bus.AWLOCK = 1'b0; bus.AWVALID = 1'b0;
        bus.WDATA = 32'd0; bus.WSTRB = 4'h0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = 32'd0; bus.ARBURST = 2'b01; bus.ARSIZE = 3'd2; bus.ARLEN = 8'd0;
        bus.ARUSER = 32'd0; bus.ARID = 16'd0; bus.ARLOCK = 1'b0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Write burst from wbuf. WLAST is driven on beat wlast_at. If abort_at >= 0,
    // reset is asserted together with that beat and no response is collected.
    task automatic do_write(input logic [15:0] id, input logic [31:0] addr, input logic [1:0] burst,
                            input logic [2:0] size, input logic [7:0] len, input logic [3:0] strb,
                            input int wlast_at, input logic lock, input int abort_at,
                            output logic [1:0] resp, output logic [15:0] bid);
        int n;
        resp = 2'bxx;
        bid  = 16'hxxxx;
        @(negedge clk);
        bus.AWADDR = addr; bus.AWBURST = burst; bus.AWSIZE = size; bus.AWLEN = len;
        bus.AWID = id; bus.AWLOCK = lock; bus.AWUSER = 32'h5A5A_0000 | 32'(id); bus.AWVALID = 1'b1;
        #1;
        n = 0;
        while (!bus.AWREADY && n < 50) begin @(negedge clk); #1; n++; end
        if (!bus.AWREADY) timeout_fail("aw_ready");
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.WDATA = wbuf[b]; bus.WSTRB = strb; bus.WLAST = (b == wlast_at); bus.WVALID = 1'b1;
            if (b == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("valids_after_reset",
                    {31'd0, (bus.WREADY | bus.BVALID | bus.RVALID | bus.AWREADY | bus.ARREADY)}, 32'd0);
                rst = 1'b0;
                bus.WVALID = 1'b0; bus.WLAST = 1'b0;
                return;
            end
            n = 0;
            while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
            if (!bus.WREADY) timeout_fail("w_ready");
            @(posedge clk); #1;
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        bus.BREADY = 1'b1;
        n = 0;
        while (!bus.BVALID && n < 50) begin @(negedge clk); n++; end
        if (!bus.BVALID) timeout_fail("b_valid");
        resp = bus.BRESP;
        bid  = bus.BID;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
    endtask

    // Read burst into rbuf/rrsp/rlst. With stall set, even beats see RREADY
    // low for one extra cycle and RDATA is checked for stability.
    task automatic do_read(input logic [15:0] id, input logic [31:0] addr, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] len, input logic lock,
                           input logic stall, output logic [15:0] rid);
        int n;
        rid = 16'hxxxx;
        @(negedge clk);
        bus.ARADDR = addr; bus.ARBURST = burst; bus.ARSIZE = size; bus.ARLEN = len;
        bus.ARID = id; bus.ARLOCK = lock; bus.ARUSER = 32'hA5A5_0000; bus.ARVALID = 1'b1;
        #1;
        n = 0;
        while (!bus.ARREADY && n < 50) begin @(negedge clk); #1; n++; end
        if (!bus.ARREADY) timeout_fail("ar_ready");
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!bus.RVALID && n < 50) begin @(negedge clk); n++; end
            if (!bus.RVALID) timeout_fail("r_valid");
            rbuf[b] = bus.RDATA;
            rrsp[b] = bus.RRESP;
            rlst[b] = bus.RLAST;
            if (b == 0) rid = bus.RID;
            if (stall && (b % 2 == 0)) begin
                @(negedge clk);
                chk("r_stall_valid", {31'd0, bus.RVALID}, 32'd1);
                chk("r_stall_data", bus.RDATA, rbuf[b]);
                chk("r_stall_last", {31'd0, bus.RLAST}, {31'd0, rlst[b]});
            end
            bus.RREADY = 1'b1;
            @(posedge clk); #1;
            bus.RREADY = 1'b0;
            chk("r_gap_valid_low", {31'd0, bus.RVALID}, 32'd0);
        end
    endtask

    initial begin
        logic [1:0]  br;
        logic [15:0] bi;
        logic [15:0] ri;
        logic [1:0]  grant;

        vecs[0] = '{32'h10,   3'd2, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h10,   3'd2, 32'hDEAD_BEEF, 2'b00};
        vecs[1] = '{32'h40,   3'd2, 32'h1234_5678, 4'hF, 2'b00, 32'h40,   3'd2, 32'h1234_5678, 2'b00};
        vecs[2] = '{32'h42,   3'd2, 32'hAABB_CCDD, 4'hC, 2'b00, 32'h40,   3'd2, 32'hAABB_5678, 2'b00};
        vecs[3] = '{32'h41,   3'd0, 32'h0000_00EE, 4'h1, 2'b00, 32'h43,   3'd2, 32'hAABB_56EE, 2'b00};
        vecs[4] = '{32'h44,   3'd2, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h44,   3'd2, 32'h0BAD_F00D, 2'b00};
        vecs[5] = '{32'h44,   3'd3, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h44,   3'd2, 32'h0BAD_F00D, 2'b00};
        vecs[6] = '{32'h48,   3'd2, 32'h600D_CAFE, 4'hF, 2'b00, 32'h48,   3'd3, 32'h0000_0000, 2'b10};
        vecs[7] = '{32'h4000, 3'd2, 32'h1111_2222, 4'hF, 2'b10, 32'h4000, 3'd2, 32'h0000_0000, 2'b10};

        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready_valid",
            {27'd0, bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID}, 32'd0);
        chk("reset_resp", {28'd0, bus.BRESP, bus.RRESP}, 32'd0);
        chk("reset_ids", {bus.BID, bus.RID}, 32'd0);
        chk("reset_rdata", bus.RDATA, 32'd0);
        chk("reset_rlast", {31'd0, bus.RLAST}, 32'd0);
        rst = 1'b0;

        // Single-beat write/read vectors.
        for (int i = 0; i < 8; i++) begin
            wbuf[0] = vecs[i].wdata;
            do_write(16'h100 + 16'(i), vecs[i].waddr, 2'b01, vecs[i].wsize, 8'd0, vecs[i].wstrb,
                     0, 1'b0, -1, br, bi);
            chk($sformatf("vec%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].exp_bresp});
            chk($sformatf("vec%0d_bid", i), {16'd0, bi}, {16'd0, 16'h100 + 16'(i)});
            do_read(16'h100 + 16'(i), vecs[i].raddr, 2'b01, vecs[i].rsize, 8'd0, 1'b0, 1'b0, ri);
            chk($sformatf("vec%0d_rdata", i), rbuf[0], vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rresp", i), {30'd0, rrsp[0]}, {30'd0, vecs[i].exp_rresp});
            chk($sformatf("vec%0d_rlast", i), {31'd0, rlst[0]}, 32'd1);
            chk($sformatf("vec%0d_rid", i), {16'd0, ri}, {16'd0, 16'h100 + 16'(i)});
        end

        // INCR LEN=3 write then read with RREADY stalls.
        for (int b = 0; b < 4; b++) wbuf[b] = 32'(b + 1);
        do_write(16'h0022, 32'h100, 2'b01, 3'd2, 8'd3, 4'hF, 3, 1'b0, -1, br, bi);
        chk("incr_bresp", {30'd0, br}, 32'd0);
        do_read(16'h0023, 32'h100, 2'b01, 3'd2, 8'd3, 1'b0, 1'b1, ri);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("incr_rdata%0d", b), rbuf[b], 32'(b + 1));
            chk($sformatf("incr_rlast%0d", b), {31'd0, rlst[b]}, {31'd0, (b == 3)});
            chk($sformatf("incr_rresp%0d", b), {30'd0, rrsp[b]}, 32'd0);
        end
        chk("incr_rid", {16'd0, ri}, 32'h0023);

        // Word i holds i, then a WRAP LEN=3 read from 0x18 and an illegal WRAP LEN=2.
        for (int b = 0; b < 8; b++) wbuf[b] = 32'(b);
        do_write(16'h0031, 32'h0, 2'b01, 3'd2, 8'd7, 4'hF, 7, 1'b0, -1, br, bi);
        chk("fill_bresp", {30'd0, br}, 32'd0);
        do_read(16'h0032, 32'h18, 2'b10, 3'd2, 8'd3, 1'b0, 1'b0, ri);
        chk("wrap_d0", rbuf[0], 32'd6);
        chk("wrap_d1", rbuf[1], 32'd7);
        chk("wrap_d2", rbuf[2], 32'd4);
        chk("wrap_d3", rbuf[3], 32'd5);
        chk("wrap_last", {28'd0, rlst[0], rlst[1], rlst[2], rlst[3]}, 32'h1);
        do_read(16'h0033, 32'h18, 2'b10, 3'd2, 8'd2, 1'b0, 1'b0, ri);
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("wrap2_rresp%0d", b), {30'd0, rrsp[b]}, 32'h2);
            chk($sformatf("wrap2_rdata%0d", b), rbuf[b], 32'd0);
        end

        // Top-of-SRAM crossing, with word 0 checked for aliasing.
        wbuf[0] = 32'h1111_1111;
        do_write(16'h0041, 32'h0, 2'b01, 3'd2, 8'd0, 4'hF, 0, 1'b0, -1, br, bi);
        wbuf[0] = 32'hCAFE_0001;
        wbuf[1] = 32'hCAFE_0002;
        do_write(16'h0042, 32'h3FFC, 2'b01, 3'd2, 8'd1, 4'hF, 1, 1'b0, -1, br, bi);
        chk("edge_bresp", {30'd0, br}, 32'h2);
        do_read(16'h0043, 32'h3FFC, 2'b01, 3'd2, 8'd0, 1'b0, 1'b0, ri);
        chk("edge_top_word", rbuf[0], 32'hCAFE_0001);
        chk("edge_top_rresp", {30'd0, rrsp[0]}, 32'd0);
        do_read(16'h0044, 32'h0, 2'b01, 3'd2, 8'd0, 1'b0, 1'b0, ri);
        chk("edge_no_alias", rbuf[0], 32'h1111_1111);
        do_read(16'h0045, 32'h4000, 2'b01, 3'd2, 8'd0, 1'b0, 1'b0, ri);
        chk("edge_oor_rresp", {30'd0, rrsp[0]}, 32'h2);
        chk("edge_oor_rdata", rbuf[0], 32'd0);

        // Arbitration after reset: the write wins first, then the read.
        pulse_reset();
        @(negedge clk);
        bus.AWADDR = 32'h300; bus.AWLEN = 8'd2; bus.AWBURST = 2'b01; bus.AWSIZE = 3'd2;
        bus.AWVALID = 1'b1; bus.ARVALID = 1'b1; bus.ARADDR = 32'h100; bus.ARLEN = 8'd0;
        #1;
        grant = {bus.AWREADY, bus.ARREADY};
        chk("arb_first_write", {30'd0, grant}, 32'h2);
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
        for (int b = 0; b < 3; b++) wbuf[b] = 32'h50 + 32'(b);
        do_write(16'h0051, 32'h300, 2'b01, 3'd2, 8'd2, 4'hF, 1, 1'b0, -1, br, bi);
        chk("early_wlast_bresp", {30'd0, br}, 32'h2);
        @(negedge clk);
        bus.AWVALID = 1'b1; bus.ARVALID = 1'b1;
        #1;
        grant = {bus.AWREADY, bus.ARREADY};
        chk("arb_second_read", {30'd0, grant}, 32'h1);
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
        do_read(16'h0052, 32'h100, 2'b01, 3'd2, 8'd0, 1'b0, 1'b0, ri);
        chk("arb_read_data", rbuf[0], 32'd1);

        // Reset during beat 2 of an INCR LEN=7 write.
        for (int b = 0; b < 8; b++) wbuf[b] = 32'hA0 + 32'(b);
        do_write(16'h0061, 32'h200, 2'b01, 3'd2, 8'd7, 4'hF, 7, 1'b0, -1, br, bi);
        for (int b = 0; b < 8; b++) wbuf[b] = 32'hB0 + 32'(b);
        do_write(16'h0062, 32'h200, 2'b01, 3'd2, 8'd7, 4'hF, 7, 1'b0, 2, br, bi);
        do_read(16'h0063, 32'h200, 2'b01, 3'd2, 8'd7, 1'b0, 1'b0, ri);
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("abort_word%0d", b), rbuf[b], (b < 2) ? 32'hB0 + 32'(b) : 32'hA0 + 32'(b));
        end

`ifdef CALIPTRA_M_AXI_RESP_EXCL_EN
        // Exclusive pair succeeds once; the repeat is refused and not written.
        do_read(16'h0077, 32'h40, 2'b01, 3'd2, 8'd0, 1'b1, 1'b0, ri);
        chk("excl_read_rresp", {30'd0, rrsp[0]}, 32'h1);
        wbuf[0] = 32'h1234_ABCD;
        do_write(16'h0077, 32'h40, 2'b01, 3'd2, 8'd0, 4'hF, 0, 1'b1, -1, br, bi);
        chk("excl_write_bresp", {30'd0, br}, 32'h1);
        do_read(16'h0078, 32'h40, 2'b01, 3'd2, 8'd0, 1'b0, 1'b0, ri);
        chk("excl_write_data", rbuf[0], 32'h1234_ABCD);
        wbuf[0] = 32'hFFFF_0000;
        do_write(16'h0077, 32'h40, 2'b01, 3'd2, 8'd0, 4'hF, 0, 1'b1, -1, br, bi);
        chk("excl_repeat_bresp", {30'd0, br}, 32'd0);
        do_read(16'h0079, 32'h40, 2'b01, 3'd2, 8'd0, 1'b0, 1'b0, ri);
        chk("excl_repeat_nowrite", rbuf[0], 32'h1234_ABCD);
`else
        // Without the monitor, a locked read is an ordinary OKAY read.
        do_read(16'h0077, 32'h40, 2'b01, 3'd2, 8'd0, 1'b1, 1'b0, ri);
        chk("lock_ignored_rresp", {30'd0, rrsp[0]}, 32'd0);
        chk("lock_ignored_rdata", rbuf[0], 32'hAABB_56EE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
